// File: rtl/crc_checker_if.sv
// Serial CRC receive link bundle: DATA/ACTIVE/CRC_IN/CRC_VALID in, status out.
// No latency of its own; pure wiring between the link source and the checker.
// No backpressure: the link is push-only and the checker must accept every bit.
interface crc_checker_if;
  logic       DATA;
  logic       ACTIVE;
  logic       CRC_IN;
  logic       CRC_VALID;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic       ERR;
  logic       ABORT;
  logic [7:0] ERR_CNT;

  // Link source side: drives the serial stream, observes verdicts.
  modport master (
    output DATA, ACTIVE, CRC_IN, CRC_VALID,
    input  BUSY, DONE, PASS, ERR, ABORT, ERR_CNT
  );

  // Checker side.
  modport slave (
    input  DATA, ACTIVE, CRC_IN, CRC_VALID,
    output BUSY, DONE, PASS, ERR, ABORT, ERR_CNT
  );
endinterface

// File: rtl/crc_checker.sv
// Serial CRC-8 checker: rebuilds the LFSR over the data bits, then compares the serial CRC.
// Verdict (DONE/PASS/ERR) registered one cycle after the last CRC bit, or after a gap/short timeout.
// No backpressure: every ACTIVE/CRC_VALID cycle is consumed; ACTIVE always wins over CRC_VALID.
module crc_checker #(
  parameter logic [7:0]  SEED    = 8'hD8,
  parameter int unsigned GAP_MAX = 4
) (
  input logic          CLK,
  input logic          RST,
  crc_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_DATA = 2'd1,
    RX_CRC  = 2'd2
  } state_t;

  // Last gap count value before the timeout fires.
  localparam logic [3:0] GAP_LAST = 4'(GAP_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       mismatch_q, mismatch_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       err_q, err_d;
  logic       abort_q, abort_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       fb;
  logic [7:0] lfsr_data;
  logic [7:0] lfsr_chk;
  logic       bit_miss;

  // Both LFSR step candidates, computed once and selected by the FSM.
  always_comb begin
    fb        = bus.DATA ^ lfsr_q[0];
    lfsr_data = {fb, lfsr_q[7] ^ fb, lfsr_q[6:4], lfsr_q[3] ^ fb, lfsr_q[2:1]};
    lfsr_chk  = {1'b0, lfsr_q[7:1]};
    bit_miss  = bus.CRC_IN ^ lfsr_q[0];
  end

  // Next state, LFSR update and one-cycle verdict/abort pulses.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        // A lone CRC_VALID with no preceding data is not a frame.
        if (bus.ACTIVE) begin
          lfsr_d    = lfsr_data;
          gap_cnt_d = 4'd0;
          state_d   = RX_DATA;
        end
      end

      RX_DATA: begin
        if (bus.ACTIVE) begin
          lfsr_d    = lfsr_data;
          gap_cnt_d = 4'd0;
        end else if (bus.CRC_VALID) begin
          lfsr_d     = lfsr_chk;
          mismatch_d = bit_miss;
          bit_cnt_d  = 3'd1;
          gap_cnt_d  = 4'd0;
          state_d    = RX_CRC;
        end else if (gap_cnt_q == GAP_LAST) begin
          // Stream stalled too long between data and CRC.
          done_d    = 1'b1;
          err_d     = 1'b1;
          gap_cnt_d = 4'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      RX_CRC: begin
        if (bus.ACTIVE) begin
          // New frame restarts mid-CRC; keep the partially shifted LFSR like the generator does.
          abort_d    = 1'b1;
          lfsr_d     = lfsr_data;
          mismatch_d = 1'b0;
          bit_cnt_d  = 3'd0;
          gap_cnt_d  = 4'd0;
          state_d    = RX_DATA;
        end else if (bus.CRC_VALID) begin
          lfsr_d = lfsr_chk;
          if (bit_cnt_q == 3'd7) begin
            done_d     = 1'b1;
            pass_d     = ~(mismatch_q | bit_miss);
            err_d      = mismatch_q | bit_miss;
            mismatch_d = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = IDLE;
          end else begin
            mismatch_d = mismatch_q | bit_miss;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end else begin
          // CRC ended early; LFSR is left where the shifting stopped.
          done_d     = 1'b1;
          err_d      = 1'b1;
          mismatch_d = 1'b0;
          bit_cnt_d  = 3'd0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      bit_cnt_q  <= 3'd0;
      gap_cnt_q  <= 4'd0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.BUSY    = (state_q != IDLE);
  assign bus.DONE    = done_q;
  assign bus.PASS    = pass_q;
  assign bus.ERR     = err_q;
  assign bus.ABORT   = abort_q;
  assign bus.ERR_CNT = err_cnt_q;

endmodule
